mux_sel_arb: RTL

MUX_SEL_ARB -- requirements
Module: mux_sel_arb

---
 rtl/mux_arb_pkg.sv | 13 +
 rtl/rr_pick.sv | 33 +++
 rtl/mux_sel_arb.sv | 119 +++++++++++
 3 files changed

// File: rtl/mux_arb_pkg.sv
// Package shared by the 4-channel round-robin mux-select arbiter.
// Holds the channel count, the select width and the arbiter state encoding.
package mux_arb_pkg;

    localparam int unsigned NUM_CH = 4;
    localparam int unsigned SEL_W  = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

endpackage : mux_arb_pkg

// File: rtl/rr_pick.sv
// Combinational round-robin picker.
// Finds the first set request bit, starting at prio and moving upward mod NUM_CH.
// Ports:
//   req   - per-channel request vector
//   prio  - channel that is searched first
//   idx   - index of the first requester in search order (0 when none)
//   found - high when any request bit is set
module rr_pick
    import mux_arb_pkg::*;
(
    input  logic [NUM_CH-1:0] req,
    input  logic [SEL_W-1:0]  prio,
    output logic [SEL_W-1:0]  idx,
    output logic              found
);

    logic [SEL_W-1:0] w_ch;

    always_comb begin
        idx   = '0;
        found = 1'b0;
        w_ch  = '0;
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            // Select-width add wraps naturally, giving the mod-NUM_CH search order.
            w_ch = prio + SEL_W'(k);
            if (!found && req[w_ch]) begin
                idx   = w_ch;
                found = 1'b1;
            end
        end
    end

endmodule : rr_pick

// File: rtl/mux_sel_arb.sv
// Round-robin arbiter driving the select of a downstream 4:1 mux.
// A grant lasts until done, until the granted request drops, or until
// MAX_BEATS cycles have elapsed; every grant is followed by one idle cycle.
// Ports:
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset
//   req   - per-channel request (a=0, b=1, c=2, d=3)
//   done  - granted channel finished (ignored while idle)
//   sel   - registered mux select, held through release
//   gnt   - registered one-hot grant, zero when idle
//   busy  - registered, high exactly when gnt is non-zero
module mux_sel_arb
    import mux_arb_pkg::*;
#(
    parameter int unsigned MAX_BEATS = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] req,
    input  logic              done,
    output logic [SEL_W-1:0]  sel,
    output logic [NUM_CH-1:0] gnt,
    output logic              busy
);

    localparam logic [3:0] BEAT_LAST = 4'(MAX_BEATS - 1);

    arb_state_t        r_state;
    logic [SEL_W-1:0]  r_sel;
    logic [NUM_CH-1:0] r_gnt;
    logic              r_busy;
    logic [SEL_W-1:0]  r_prio;
    logic [3:0]        r_beat;

    arb_state_t        w_state_nxt;
    logic [SEL_W-1:0]  w_sel_nxt;
    logic [NUM_CH-1:0] w_gnt_nxt;
    logic              w_busy_nxt;
    logic [SEL_W-1:0]  w_prio_nxt;
    logic [3:0]        w_beat_nxt;

    logic [SEL_W-1:0]  w_idx;
    logic              w_found;
    logic              w_release;

    rr_pick u_pick (
        .req   (req),
        .prio  (r_prio),
        .idx   (w_idx),
        .found (w_found)
    );

    assign w_release = done || !req[r_sel] || (r_beat == BEAT_LAST);

    always_comb begin
        w_state_nxt = r_state;
        w_sel_nxt   = r_sel;
        w_gnt_nxt   = r_gnt;
        w_busy_nxt  = r_busy;
        w_prio_nxt  = r_prio;
        w_beat_nxt  = r_beat;
        unique case (r_state)
            IDLE: begin
                if (w_found) begin
                    w_state_nxt        = GRANT;
                    w_sel_nxt          = w_idx;
                    w_gnt_nxt          = '0;
                    w_gnt_nxt[w_idx]   = 1'b1;
                    w_busy_nxt         = 1'b1;
                    w_beat_nxt         = '0;
                end
            end
            GRANT: begin
                if (w_release) begin
                    // sel stays put so the downstream mux does not glitch on release.
                    w_state_nxt = IDLE;
                    w_gnt_nxt   = '0;
                    w_busy_nxt  = 1'b0;
                    w_prio_nxt  = r_sel + SEL_W'(1);
                end else begin
                    w_beat_nxt  = r_beat + 4'd1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_sel   <= '0;
            r_gnt   <= '0;
            r_busy  <= 1'b0;
            r_prio  <= '0;
            r_beat  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_sel   <= w_sel_nxt;
            r_gnt   <= w_gnt_nxt;
            r_busy  <= w_busy_nxt;
            r_prio  <= w_prio_nxt;
            r_beat  <= w_beat_nxt;
        end
    end

    assign sel  = r_sel;
    assign gnt  = r_gnt;
    assign busy = r_busy;

    // Output consistency checks, sampled on the registered values before the edge.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            assert ($onehot0(r_gnt)) else $error("gnt not one-hot-or-zero: %b", r_gnt);
            assert (r_busy == |r_gnt) else $error("busy %b disagrees with gnt %b", r_busy, r_gnt);
            assert (r_gnt[r_sel] == r_busy) else $error("gnt[sel] disagrees with busy");
        end
    end

endmodule : mux_sel_arb
